// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch stage: jump_type codes, FSM state encoding
// and a small alignment helper.
package fetch_pc_pkg;

  localparam logic [2:0] JT_SEQ    = 3'b000;
  localparam logic [2:0] JT_BEQ    = 3'b001;
  localparam logic [2:0] JT_JAL_JR = 3'b011;
  localparam logic [2:0] JT_J      = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Instruction-memory request/valid bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_pc_if #(
  parameter int DWIDTH = 32
) ();

  logic              req;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] rdata;
  logic              valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);

endinterface

// File: rtl/fetch_pc_next_pc_calc.sv
// Next-PC target mux for the fetch stage; the result is word-aligned and the
// discarded low bits are reported as misalign.
module next_pc_calc
  import fetch_pc_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] pc_plus4_i,
  input  logic [2:0]        jump_type_i,
  input  logic              is_jr_i,
  input  logic [DWIDTH-1:0] jump_addr_i,
  input  logic [DWIDTH-1:0] branch_imm_i,
  input  logic              branch_taken_i,
  input  logic [DWIDTH-1:0] jr_target_i,
  output logic [DWIDTH-1:0] next_pc_o,
  output logic              misalign_o
);

  logic [DWIDTH-1:0] raw_pc_s;
  logic [DWIDTH-1:0] jmp_target_s;
  logic [DWIDTH-1:0] br_target_s;
  logic              unused_bits_s;

  // J-format keeps the region bits of pc+4; branch offset is in words
  assign jmp_target_s  = {pc_plus4_i[DWIDTH-1:28], jump_addr_i[25:0], 2'b00};
  assign br_target_s   = pc_plus4_i + {branch_imm_i[DWIDTH-3:0], 2'b00};
  assign unused_bits_s = ^{jump_addr_i[DWIDTH-1:26], branch_imm_i[DWIDTH-1:DWIDTH-2]};

  always_comb begin
    raw_pc_s = pc_plus4_i;
    case (jump_type_i)
      JT_SEQ: raw_pc_s = pc_plus4_i;
      JT_BEQ: begin
        if (branch_taken_i) raw_pc_s = br_target_s;
        else                raw_pc_s = pc_plus4_i;
      end
      JT_JAL_JR: begin
        if (is_jr_i) raw_pc_s = jr_target_i;
        else         raw_pc_s = jmp_target_s;
      end
      JT_J:    raw_pc_s = jmp_target_s;
      default: raw_pc_s = pc_plus4_i;
    endcase
  end

  assign next_pc_o  = {raw_pc_s[DWIDTH-1:2], 2'b00};
  assign misalign_o = is_misaligned(raw_pc_s[1:0]);

endmodule

// File: rtl/fetch_pc.sv
// Instruction-fetch stage: owns the PC, runs the imem request/valid handshake
// and hands one captured instruction at a time to decode.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter int                 DWIDTH   = 32,
  parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_pc_if.master        imem,
  input  logic [2:0]        jump_type_i,
  input  logic              is_jr_i,
  input  logic [DWIDTH-1:0] jump_addr_i,
  input  logic [DWIDTH-1:0] branch_imm_i,
  input  logic              branch_taken_i,
  input  logic [DWIDTH-1:0] jr_target_i,
  input  logic              stall_i,
  output logic [DWIDTH-1:0] instr_o,
  output logic              instr_valid_o,
  output logic [DWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] pc_plus4_o,
  output logic              misalign_o,
  output logic [31:0]       retired_o
);

  localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(32'd4);

  state_t            state_q;
  logic [DWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] pc_plus4_q;
  logic [DWIDTH-1:0] instr_q;
  logic              req_q;
  logic              instr_valid_q;
  logic              misalign_q;
  logic [31:0]       retired_q;
  logic [DWIDTH-1:0] next_pc_d;
  logic              misalign_d;

  next_pc_calc #(.DWIDTH(DWIDTH)) u_next_pc_calc (
    .pc_plus4_i     (pc_plus4_q),
    .jump_type_i    (jump_type_i),
    .is_jr_i        (is_jr_i),
    .jump_addr_i    (jump_addr_i),
    .branch_imm_i   (branch_imm_i),
    .branch_taken_i (branch_taken_i),
    .jr_target_i    (jr_target_i),
    .next_pc_o      (next_pc_d),
    .misalign_o     (misalign_d)
  );

  // Fetch FSM; pc_plus4 is kept as its own register so the link value is a clean flop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + PC_STEP;
      instr_q       <= '0;
      req_q         <= 1'b0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      retired_q     <= 32'd0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.valid) begin
            instr_q       <= imem.rdata;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_EXEC;
          end
        end
        S_EXEC: begin
          // a stalled cycle holds everything; the target is recomputed on release
          if (!stall_i) begin
            pc_q          <= next_pc_d;
            pc_plus4_q    <= next_pc_d + PC_STEP;
            retired_q     <= retired_q + 32'd1;
            misalign_q    <= misalign_d;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b1;
            state_q       <= S_FETCH;
          end
        end
        default: begin
          req_q         <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign imem.req      = req_q;
  assign imem.addr     = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign misalign_o    = misalign_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: a small imem responder plus queues of expected
// fetch addresses and instruction words.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  jump_type = 3'b000;
  logic        is_jr = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic [31:0] branch_imm = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 32'h0;
  logic [31:0] last_instr = 32'h0;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];

  fetch_pc_if #(.DWIDTH(32)) imem_if ();

  fetch_pc #(.DWIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_if),
    .jump_type_i    (jump_type),
    .is_jr_i        (is_jr),
    .jump_addr_i    (jump_addr),
    .branch_imm_i   (branch_imm),
    .branch_taken_i (branch_taken),
    .jr_target_i    (jr_target),
    .stall_i        (stall),
    .instr_o        (instr),
    .instr_valid_o  (instr_valid),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
    .misalign_o     (misalign),
    .retired_o      (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8C5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request and compare its address with the scoreboard
  task automatic fetch(input string tag, input int lat);
    int n;
    logic [31:0] a;
    n = 0;
    while (imem_if.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'd0, imem_if.req}, 32'd1);
    a = addr_q.pop_front();
    chk({tag, "_addr"}, imem_if.addr, a);
    chk({tag, "_pc"}, pc, a);
    for (int i = 1; i < lat; i++) @(negedge clk);
    imem_if.valid = 1'b1;
    imem_if.rdata = mem_word(imem_if.addr);
    instr_q.push_back(imem_if.rdata);
    @(negedge clk);
    imem_if.valid = 1'b0;
    imem_if.rdata = 32'h0;
    last_instr = instr_q.pop_front();
    chk({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, last_instr);
  endtask

  task automatic commit(input string tag, input logic [2:0] jt, input logic jr,
                        input logic [31:0] ja, input logic [31:0] imm, input logic tk,
                        input logic [31:0] jrt, input logic [31:0] exp_next, input logic exp_mis);
    jump_type = jt; is_jr = jr; jump_addr = ja; branch_imm = imm;
    branch_taken = tk; jr_target = jrt; stall = 1'b0;
    addr_q.push_back(exp_next);
    @(negedge clk);
    exp_ret = exp_ret + 32'd1;
    chk({tag, "_retired"}, retired, exp_ret);
    chk({tag, "_misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
    chk({tag, "_ivalid_fall"}, {31'd0, instr_valid}, 32'd0);
    if (exp_mis) begin
      @(negedge clk);
      chk({tag, "_misalign_pulse"}, {31'd0, misalign}, 32'd0);
    end
    jump_type = 3'b000; is_jr = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    imem_if.valid = 1'b0;
    imem_if.rdata = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_if.req}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    addr_q.push_back(32'h0);

    // sequential fetches, then a jump to 0x40
    fetch("t1_0", 1);  commit("t1_0", 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    fetch("t1_4", 1);  commit("t1_4", 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h8, 1'b0);
    fetch("t1_8", 2);  commit("t1_8", 3'b100, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0);

    // backward branch taken / not taken
    fetch("t2_40", 1);
    chk("t2_pc4", pc_plus4, 32'h44);
    commit("t2_bt", 3'b001, 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b1, 32'h0, 32'h3C, 1'b0);
    fetch("t2_3c", 3); commit("t2_seq", 3'b111, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h40, 1'b0);
    fetch("t2_40b", 1);
    commit("t2_bn", 3'b001, 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h44, 1'b0);

    // j and jal keep pc+4 region bits
    fetch("t3_44", 1); commit("t3_jr", 3'b011, 1'b1, 32'h0, 32'h0, 1'b0, 32'h1000_0010, 32'h1000_0010, 1'b0);
    fetch("t3_a", 1);
    chk("t3_pc4", pc_plus4, 32'h1000_0014);
    commit("t3_j", 3'b100, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 32'h1000_0400, 1'b0);
    fetch("t3_b", 2);  commit("t3_jr2", 3'b011, 1'b1, 32'h0, 32'h0, 1'b0, 32'h1000_0010, 32'h1000_0010, 1'b0);
    fetch("t3_c", 1);
    chk("t3_jal_link", pc_plus4, 32'h1000_0014);
    commit("t3_jal", 3'b011, 1'b0, 32'hFC00_0100, 32'h0, 1'b0, 32'h0, 32'h1000_0400, 1'b0);

    // misaligned jr target
    fetch("t4_a", 1);  commit("t4_jr", 3'b011, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_0206, 32'h0000_0204, 1'b1);

    // top-of-memory wrap of pc+4
    fetch("t4_b", 1);  commit("wr_jr", 3'b011, 1'b1, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    fetch("wr", 2);
    chk("wr_pc4", pc_plus4, 32'h0);

    // stall with a pending jump; stray imem_valid must be ignored
    jump_type = 3'b100; jump_addr = 32'h20; stall = 1'b1;
    imem_if.valid = 1'b1; imem_if.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_if.valid = 1'b0;
      chk("t5_pc", pc, 32'hFFFF_FFFC);
      chk("t5_instr", instr, last_instr);
      chk("t5_retired", retired, exp_ret);
      chk("t5_ivalid", {31'd0, instr_valid}, 32'd1);
      chk("t5_req", {31'd0, imem_if.req}, 32'd0);
    end
    commit("t5_rel", 3'b100, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h80, 1'b0);

    // reset while a fetch is outstanding
    begin
      int n;
      logic [31:0] a;
      n = 0;
      while (imem_if.req !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      a = addr_q.pop_front();
      chk("t6_addr", imem_if.addr, a);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_if.req}, 32'd0);
    chk("t6_pc", pc, 32'h0);
    chk("t6_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("t6_retired", retired, 32'h0);
    exp_ret = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    addr_q.push_back(32'h0);
    fetch("t6_0", 1);  commit("t6_0", 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    fetch("t6_4", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
